// File: rtl/ks_param_data_path.sv
// ks_param_data_path: parametrised K&S datapath with PC, IR, register file, 4-op ALU and registered flags.
// Define KS_DP_R0_ZERO_EN to hard-wire reg[0] to zero (reads 0, writes discarded).
module ks_param_data_path #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5,
   parameter int NREGS  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              branch,
   input  logic              pc_enable,
   input  logic              ir_enable,
   input  logic              addr_sel,
   input  logic              c_sel,
   input  logic [1:0]        operation,
   input  logic              write_reg_enable,
   input  logic              flags_reg_enable,
   output logic [DATA_W-1:0] instruction,
   output logic              zero_op,
   output logic              neg_op,
   output logic              unsigned_overflow,
   output logic              signed_overflow,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] data_out,
   input  logic [DATA_W-1:0] data_in
);
   localparam int RAW = $clog2(NREGS);
   localparam int MSB = DATA_W - 1;
   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] regs [NREGS];

   logic [RAW-1:0]    a_addr;
   logic [RAW-1:0]    b_addr;
   logic [RAW-1:0]    c_addr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] a_val;
   logic [DATA_W-1:0] b_val;
   logic [DATA_W-1:0] c_val;
   logic              reg_we;

   logic [DATA_W:0]   alu_ext;
   logic [DATA_W-1:0] alu_result;
   logic              alu_uovf;
   logic              alu_sovf;

   assign c_addr   = ir[RAW-1:0];
   assign b_addr   = ir[2*RAW-1:RAW];
   assign a_addr   = ir[3*RAW-1:2*RAW];
   assign mem_addr = ir[ADDR_W-1:0];

`ifdef KS_DP_R0_ZERO_EN
   assign a_val  = (a_addr == '0) ? '0 : regs[a_addr];
   assign b_val  = (b_addr == '0) ? '0 : regs[b_addr];
   assign reg_we = write_reg_enable && (c_addr != '0);
`else
   assign a_val  = regs[a_addr];
   assign b_val  = regs[b_addr];
   assign reg_we = write_reg_enable;
`endif

   // The extra top bit of alu_ext is the carry for ADD and the borrow for SUB.
   always_comb begin
      alu_ext    = '0;
      alu_result = '0;
      alu_uovf   = 1'b0;
      alu_sovf   = 1'b0;
      case (operation)
         2'b00: begin
            alu_ext    = {1'b0, a_val} + {1'b0, b_val};
            alu_result = alu_ext[MSB:0];
            alu_uovf   = alu_ext[DATA_W];
            alu_sovf   = (a_val[MSB] == b_val[MSB]) && (alu_result[MSB] != a_val[MSB]);
         end
         2'b01: begin
            alu_ext    = {1'b0, a_val} - {1'b0, b_val};
            alu_result = alu_ext[MSB:0];
            alu_uovf   = alu_ext[DATA_W];
            alu_sovf   = (a_val[MSB] != b_val[MSB]) && (alu_result[MSB] != a_val[MSB]);
         end
         2'b10:   alu_result = a_val | b_val;
         default: alu_result = a_val & b_val;
      endcase
   end

   assign c_val = c_sel ? data_in : alu_result;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= '0;
         ir <= '0;
      end else begin
         if (pc_enable)
            pc <= branch ? mem_addr : pc + PC_STEP;
         if (ir_enable)
            ir <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (reg_we) begin
         regs[c_addr] <= c_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_op           <= 1'b0;
         neg_op            <= 1'b0;
         unsigned_overflow <= 1'b0;
         signed_overflow   <= 1'b0;
      end else if (flags_reg_enable) begin
         zero_op           <= (alu_result == '0);
         neg_op            <= alu_result[MSB];
         unsigned_overflow <= alu_uovf;
         signed_overflow   <= alu_sovf;
      end
   end

   assign instruction = ir;
   assign ram_addr    = addr_sel ? mem_addr : pc;
   assign data_out    = a_val;

endmodule

// File: doc/ks_param_data_path.md
# ks_param_data_path

Parametrised K&S datapath. It holds the program counter, the instruction register, an N-entry register file, a 4-operation ALU and a registered 4-bit flag set. It sits between the K&S control unit, which drives every enable/select, and the single-port program/data RAM. Width, address space and register count are parameters. All four flags are registered, and PC/IR updates are gated by their enables.

## Interface
Parameters:
- `DATA_W`, 16: data, instruction and register width; must be ≥ 16.
- `ADDR_W`, 5: RAM address and PC width; must be ≤ `DATA_W`-8.
- `NREGS`, 4: register count; power of 2, ≥ 2. `RAW` = $clog2(`NREGS`), with 3·`RAW` ≤ `DATA_W`-8.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `branch` input 1: with `pc_enable`, PC loads the IR address field instead of incrementing.
- `pc_enable` input 1: PC update enable.
- `ir_enable` input 1: IR loads `data_in`.
- `addr_sel` input 1: 1 selects the IR address field onto `ram_addr`; 0 selects the PC.
- `c_sel` input 1: register write source; 1 selects `data_in`, 0 selects the ALU result.
- `operation` input 2: ALU op; 00 ADD, 01 SUB, 10 OR, 11 AND.
- `write_reg_enable` input 1: write C into `reg[c_addr]`.
- `flags_reg_enable` input 1: capture the ALU flags.
- `instruction` output `DATA_W`: current IR contents; the control unit decodes `instruction[DATA_W-1 -: 8]`.
- `zero_op`, `neg_op`, `unsigned_overflow`, `signed_overflow` output 1 each: registered flags.
- `ram_addr` output `ADDR_W`: RAM address.
- `data_out` output `DATA_W`: store data, equal to operand A.
- `data_in` input `DATA_W`: RAM read data.

## Operation
- IR field map:
  - `c_addr` = IR[`RAW`-1:0]
  - `b_addr` = IR[2·`RAW`-1:`RAW`]
  - `a_addr` = IR[3·`RAW`-1:2·`RAW`]
  - `mem_addr` = IR[`ADDR_W`-1:0]
- Register file reads are asynchronous: A = `reg[a_addr]`, B = `reg[b_addr]`. Write is synchronous when `write_reg_enable`=1.
- ALU is combinational, `DATA_W` wide, modulo 2^`DATA_W`.
  - ADD: uovf = carry out; sovf = operands of equal sign and result sign differs.
  - SUB (A−B): uovf = borrow (A < B unsigned); sovf = operand signs differ and result sign differs from A.
  - OR / AND: uovf = sovf = 0.
  - zero = (result == 0); neg = result MSB.
- Flags: all four are captured together when `flags_reg_enable`=1, otherwise they hold.
- PC: when `pc_enable`=1, PC ← `mem_addr` if `branch`=1, else PC+1. It wraps from 2^`ADDR_W`-1 to 0. `branch` without `pc_enable` is ignored.
- IR: when `ir_enable`=1, IR ← `data_in`.
- `ram_addr` = `addr_sel` ? `mem_addr` : PC, combinational. `data_out` = A, combinational.

## Timing
- Reset (`rst_n`=0, asynchronous, any time including mid-instruction) clears PC, IR, all registers and all four flags. Consequently `instruction`=0, `data_out`=0 and `ram_addr`=0.
- PC, IR, register and flag updates are visible the cycle after the enabling edge. `ram_addr` and `data_out` follow with zero latency.
- Same-edge `ir_enable` and `write_reg_enable`/`flags_reg_enable`: register addresses and the ALU use the old IR.
- Same-edge `ir_enable`, `pc_enable` and `branch`: the branch target is taken from the old IR.
- Write to the register currently read as A or B: the read shows the old value until after the edge. There is no bypass.
- A load (`c_sel`=1) writes `data_in` as sampled at the write edge.

## Configuration
- `KS_DP_R0_ZERO_EN` defined: `reg[0]` reads constant 0 and writes to it are discarded.
- `KS_DP_R0_ZERO_EN` undefined: `reg[0]` is an ordinary writable register, as in the baseline K&S.

## Test plan
- Reset mid-run: set PC=7, `reg1`=0x1234, flags=1111, then pulse `rst_n` low between edges → all outputs go to 0 immediately, before the next edge.
- ADD overflow: A=0x7FFF, B=0x0001, ADD with flags enabled → next cycle result written = 0x8000, neg=1, sovf=1, uovf=0, zero=0.
- SUB borrow: A=0x0000, B=0x0001, SUB → result 0xFFFF, uovf=1, sovf=0, neg=1. Then repeat with A=B=0x0005 → zero=1, uovf=0.
- PC wrap and branch:
  - PC=31 (`ADDR_W`=5) with `pc_enable` → PC=0.
  - IR address field=0x13 with `branch`=1 and `pc_enable`=1 → PC=0x13.
  - `branch`=1 with `pc_enable`=0 → PC holds.
- Load/store path: `addr_sel`=1 drives `ram_addr`=IR address field; with `c_sel`=1, `data_in`=0xBEEF and write enabled → the target register becomes 0xBEEF. Setting `a_addr` to that register → `data_out`=0xBEEF.
- Parameter/macro sweep:
  - `DATA_W`=32, `NREGS`=8: 0xFFFFFFFF+1 → zero=1, uovf=1.
  - With `KS_DP_R0_ZERO_EN`: writing 0x5555 to `reg0` → `reg0` still reads 0.
